// File: rtl/sdc_spi.sv
// sdc_spi: SPI-mode (mode 0) byte engine for the SD card slot, exposed as a stb/we/ack bus slave.
// A DATA write shifts one byte out on CMD (MSB first) while shifting DAT0 in; busy stalls DATA accesses via ack.
module sdc_spi #(
   parameter int DIV_SLOW = 125,
   parameter int DIV_FAST = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stb,
   input  logic        we,
   input  logic        addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        ack,
   output logic        sdcard_clk,
   inout  wire         sdcard_cmd,
   inout  wire  [3:0]  sdcard_dat,
   input  logic        sdcard_wp,
   output logic [1:0]  o_dbg_state
);

   localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
   localparam int CW      = $clog2(DIV_MAX);
   localparam logic [CW-1:0] SLOW_M1 = CW'(DIV_SLOW - 1);
   localparam logic [CW-1:0] FAST_M1 = CW'(DIV_FAST - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   r_div_m1;
   logic [2:0]      r_bitcnt;
   logic [7:0]      r_txshift;
   logic [7:0]      r_rxshift;
   logic [7:0]      r_rxbyte;
   logic            r_busy;
   logic            r_sclk;
   logic            r_mosi;
   logic            r_cs;
   logic            r_fast;
   logic            r_miso_meta;
   logic            r_miso_s;

   logic            w_start;
   logic            w_ctrl_wr;
   logic [7:0]      w_rx_next;
   logic            w_unused;

   assign w_start   = stb & we & addr & ~r_busy;
   assign w_ctrl_wr = stb & we & ~addr;
   assign w_rx_next = {r_rxshift[6:0], r_miso_s};

   // CTRL/STATUS never stalls; DATA accesses wait for the shifter to go idle.
   assign ack = stb & (~addr | ~r_busy);

   always_comb begin
      data_out = 32'h0;
      if (stb) begin
         if (addr) begin
            data_out = {24'h0, r_rxbyte};
         end else begin
            data_out = {22'h0, sdcard_wp, r_busy, 6'h0, r_fast, r_cs};
         end
      end
   end

   assign sdcard_clk      = r_sclk;
   assign sdcard_cmd      = r_mosi;
   assign sdcard_dat[3]   = ~r_cs;
   assign sdcard_dat[2:0] = 3'bzzz;
   assign o_dbg_state     = r_state;

   assign w_unused = ^{data_in[31:8], sdcard_dat[3:1]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_div_m1    <= '0;
         r_bitcnt    <= 3'd0;
         r_txshift   <= 8'h00;
         r_rxshift   <= 8'h00;
         r_rxbyte    <= 8'h00;
         r_busy      <= 1'b0;
         r_sclk      <= 1'b0;
         r_mosi      <= 1'b1;
         r_cs        <= 1'b0;
         r_fast      <= 1'b0;
         r_miso_meta <= 1'b0;
         r_miso_s    <= 1'b0;
      end else begin
         r_miso_meta <= sdcard_dat[0];
         r_miso_s    <= r_miso_meta;

         if (w_ctrl_wr) begin
            r_cs   <= data_in[0];
            r_fast <= data_in[1];
         end

         case (r_state)
            ST_IDLE: begin
               r_sclk <= 1'b0;
               if (w_start) begin
                  r_txshift <= data_in[7:0];
                  r_mosi    <= data_in[7];
                  r_div_m1  <= r_fast ? FAST_M1 : SLOW_M1;
                  r_cnt     <= r_fast ? FAST_M1 : SLOW_M1;
                  r_bitcnt  <= 3'd7;
                  r_busy    <= 1'b1;
                  r_state   <= ST_LOW;
               end
            end
            ST_LOW: begin
               if (r_cnt == '0) begin
                  r_sclk  <= 1'b1;
                  r_cnt   <= r_div_m1;
                  r_state <= ST_HIGH;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_HIGH: begin
               // Sampling at the very end of the high phase gives the synchronizer a full half-period.
               if (r_cnt == '0) begin
                  r_sclk    <= 1'b0;
                  r_rxshift <= w_rx_next;
                  if (r_bitcnt == 3'd0) begin
                     r_rxbyte <= w_rx_next;
                     r_mosi   <= 1'b1;
                     r_busy   <= 1'b0;
                     r_state  <= ST_IDLE;
                  end else begin
                     r_bitcnt  <= r_bitcnt - 1'b1;
                     r_txshift <= {r_txshift[6:0], 1'b0};
                     r_mosi    <= r_txshift[6];
                     r_cnt     <= r_div_m1;
                     r_state   <= ST_LOW;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdc_spi.sv
// tb_sdc_spi: directed scoreboard bench for sdc_spi with a small SD card MISO model.
// Read data and CMD bits/SCLK high lengths are queued at issue and checked by independent monitors.
module tb_sdc_spi;

   localparam int DIV_SLOW = 8;
   localparam int DIV_FAST = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stb = 1'b0;
   logic        we = 1'b0;
   logic        addr = 1'b0;
   logic [31:0] data_in = 32'h0;
   logic [31:0] data_out;
   logic        ack;
   logic        sdcard_clk;
   wire         sdcard_cmd;
   wire  [3:0]  sdcard_dat;
   logic        sdcard_wp = 1'b0;
   logic [1:0]  dbg_state;

   logic [7:0]  card_byte = 8'hFF;
   logic [2:0]  card_idx;
   wire         card_miso;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   logic [31:0] exp_q[$];
   logic [8:0]  bit_q[$];

   sdc_spi #(.DIV_SLOW(DIV_SLOW), .DIV_FAST(DIV_FAST)) dut (
      .clk         (clk),
      .rst         (rst),
      .stb         (stb),
      .we          (we),
      .addr        (addr),
      .data_in     (data_in),
      .data_out    (data_out),
      .ack         (ack),
      .sdcard_clk  (sdcard_clk),
      .sdcard_cmd  (sdcard_cmd),
      .sdcard_dat  (sdcard_dat),
      .sdcard_wp   (sdcard_wp),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Card side: presents the next bit MSB-first after every SCLK falling edge.
   always @(negedge sdcard_clk or negedge rst) begin
      if (!rst) card_idx <= 3'd0;
      else      card_idx <= card_idx + 3'd1;
   end
   assign card_miso     = card_byte[3'd7 - card_idx];
   assign sdcard_dat[0] = card_miso;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endfunction

   function automatic void fail_now(string name);
      n_checks++;
      $display("FAIL %s: got no completion expected completion", name);
   endfunction

   // ---------------- monitors ----------------
   logic [31:0] mon_exp;
   always @(negedge clk) begin
      if (stb && !we && ack) begin
         if (exp_q.size() == 0) fail_now("read_unexpected");
         else begin
            mon_exp = exp_q.pop_front();
            check("read_data", data_out, mon_exp);
         end
      end
   end

   logic       prev_sclk = 1'b0;
   logic       rise_cmd = 1'b0;
   int         hi_cnt = 0;
   logic [8:0] bexp;
   always @(negedge clk) begin
      if (!rst) begin
         prev_sclk = 1'b0;
         hi_cnt    = 0;
      end else begin
         if (sdcard_clk && !prev_sclk) begin
            rise_cmd = sdcard_cmd;
            hi_cnt   = 1;
         end else if (sdcard_clk) begin
            hi_cnt++;
         end else if (prev_sclk) begin
            if (bit_q.size() == 0) fail_now("sclk_unexpected");
            else begin
               bexp = bit_q.pop_front();
               check("mosi_bit", {31'h0, rise_cmd}, {31'h0, bexp[0]});
               check("sclk_high_len", hi_cnt, {24'h0, bexp[8:1]});
            end
         end
         prev_sclk = sdcard_clk;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic bus_read(input logic a, input logic [31:0] exp, output int ack_cyc);
      int w;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      stb = 1'b1; we = 1'b0; addr = a;
      w = 0; ack_cyc = -1;
      while (ack_cyc < 0 && w < 2000) begin
         @(negedge clk); w++;
         if (ack) ack_cyc = cyc;
      end
      if (ack_cyc < 0) fail_now("read_ack_timeout");
      @(posedge clk); #1;
      stb = 1'b0;
   endtask

   task automatic bus_write(input logic a, input logic [31:0] d, input int half,
                            output int acc_cyc, output int waits);
      int h;
      h = half;
      if (a) for (int i = 7; i >= 0; i--) bit_q.push_back({h[7:0], d[i]});
      @(posedge clk); #1;
      stb = 1'b1; we = 1'b1; addr = a; data_in = d;
      waits = 0; acc_cyc = -1;
      while (acc_cyc < 0 && waits < 2000) begin
         @(negedge clk); waits++;
         if (ack) acc_cyc = cyc + 1;
      end
      if (acc_cyc < 0) fail_now("write_ack_timeout");
      @(posedge clk); #1;
      stb = 1'b0; we = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t_acc, t_ack, t_w, acc_a, t_dummy;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_sclk", {31'h0, sdcard_clk}, 32'h0);
      check("rst_cmd", {31'h0, sdcard_cmd}, 32'h1);
      check("rst_cs_n", {31'h0, sdcard_dat[3]}, 32'h1);
      check("rst_dout_idle", data_out, 32'h0);
      bus_read(1'b0, 32'h0, t_ack);
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_sclk", {31'h0, sdcard_clk}, 32'h0);
      check("post_rst_cmd", {31'h0, sdcard_cmd}, 32'h1);
      check("post_rst_cs_n", {31'h0, sdcard_dat[3]}, 32'h1);

      // CTRL / STATUS and write-protect
      bus_write(1'b0, 32'h3, 0, t_dummy, t_w);
      check("ctrl_ack_wait", t_w, 1);
      bus_read(1'b0, 32'h003, t_ack);
      check("cs_asserted", {31'h0, sdcard_dat[3]}, 32'h0);
      sdcard_wp = 1'b1;
      bus_read(1'b0, 32'h203, t_ack);
      sdcard_wp = 1'b0;
      bus_read(1'b0, 32'h003, t_ack);

      // Fast byte: A5 out, 3C in
      card_byte = 8'h3C;
      bus_write(1'b1, 32'hA5, DIV_FAST, t_acc, t_w);
      check("fast_accept_wait", t_w, 1);
      bus_read(1'b1, 32'h3C, t_ack);
      check("fast_busy_len", t_ack - t_acc, 64);
      check("idle_cmd_high", {31'h0, sdcard_cmd}, 32'h1);

      // Slow byte, fast switched on mid-transfer
      bus_write(1'b0, 32'h1, 0, t_dummy, t_w);
      card_byte = 8'hFF;
      bus_write(1'b1, 32'hFF, DIV_SLOW, t_acc, t_w);
      bus_read(1'b0, 32'h101, t_ack);
      bus_write(1'b0, 32'h3, 0, t_dummy, t_w);
      check("ctrl_while_busy_wait", t_w, 1);
      bus_read(1'b0, 32'h103, t_ack);
      bus_read(1'b1, 32'hFF, t_ack);
      check("slow_busy_len", t_ack - t_acc, 128);
      bus_write(1'b1, 32'h0F, DIV_FAST, t_acc, t_w);
      bus_read(1'b1, 32'hFF, t_ack);
      check("fast_after_switch_len", t_ack - t_acc, 64);

      // Back-to-back: second write stalls 10 cycles into the first
      card_byte = 8'h96;
      bus_write(1'b1, 32'h5A, DIV_FAST, acc_a, t_w);
      repeat (9) @(posedge clk);
      bus_write(1'b1, 32'hC3, DIV_FAST, t_acc, t_w);
      check("stall_write_waits", t_w, 55);
      check("stall_write_accept", t_acc - acc_a, 65);
      bus_read(1'b1, 32'h96, t_ack);
      check("stall_read_len", t_ack - t_acc, 64);

      // Reset during bit 3 (SCLK high, CMD = 0)
      card_byte = 8'h3C;
      bus_write(1'b1, 32'hA5, DIV_FAST, t_acc, t_w);
      repeat (29) @(posedge clk);
      #2;
      check("pre_abort_sclk", {31'h0, sdcard_clk}, 32'h1);
      check("pre_abort_cmd", {31'h0, sdcard_cmd}, 32'h0);
      #1 rst = 1'b0;
      #1;
      check("abort_sclk", {31'h0, sdcard_clk}, 32'h0);
      check("abort_cmd", {31'h0, sdcard_cmd}, 32'h1);
      check("abort_cs_n", {31'h0, sdcard_dat[3]}, 32'h1);
      bus_read(1'b0, 32'h000, t_ack);
      bit_q.delete();
      @(posedge clk); #1 rst = 1'b1;
      bus_write(1'b0, 32'h3, 0, t_dummy, t_w);
      bus_write(1'b1, 32'h1234_56A5, DIV_FAST, t_acc, t_w);
      check("recover_accept_wait", t_w, 1);
      bus_read(1'b1, 32'h3C, t_ack);
      check("recover_busy_len", t_ack - t_acc, 64);

      // DATA write pattern with stb low must not start anything
      addr = 1'b1; we = 1'b1; data_in = 32'h55;
      repeat (20) @(posedge clk);
      #1 we = 1'b0; addr = 1'b0;
      bus_read(1'b0, 32'h003, t_ack);
      @(negedge clk);
      check("dout_zero_idle", data_out, 32'h0);

      repeat (40) @(posedge clk);
      check("bit_q_drained", bit_q.size(), 32'h0);
      check("exp_q_drained", exp_q.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

endmodule
